// File: rtl/cpu10_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu10_pkg
// Brief  : Shared widths and arbiter FSM state encoding.
// Rev    : 1.0
// ============================================================================
package cpu10_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// ============================================================================
// Module : arb_pick2
// Brief  : Two-way port selector, round-robin or fixed priority (port 0).
// Rev    : 1.0
// ============================================================================
module arb_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic rr,
  output logic sel,
  output logic any
);

  always_comb begin
    any = req0 | req1;
    sel = 1'b0;
    if (req0 && req1) begin
      // On conflict round-robin favours the port not granted last.
      sel = rr ? ~last : 1'b0;
    end else begin
      sel = req1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_arbiter
// Brief  : Two-port arbiter in front of a 1024x10 synchronous RAM.
// Rev    : 1.0
// ============================================================================
module ram_arbiter
  import cpu10_pkg::*;
#(
  parameter logic RR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e              state_q, state_d;
  logic                port_q,  port_d;
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          gnt_q,   gnt_d;
  logic                last_q,  last_d;
  logic                w_sel;
  logic                w_any;

  arb_pick2 u_pick (
    .req0 (p0_req),
    .req1 (p1_req),
    .last (last_q),
    .rr   (RR),
    .sel  (w_sel),
    .any  (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = 2'b00;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (w_any) begin
          port_d  = w_sel;
          we_d    = w_sel ? p1_we    : p0_we;
          addr_d  = w_sel ? p1_addr  : p0_addr;
          wdata_d = w_sel ? p1_wdata : p0_wdata;
          gnt_d   = w_sel ? 2'b10 : 2'b01;
          last_d  = w_sel;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // ACCESS spans the grant cycle plus the RAM cycle.
        if (gnt_q == 2'b00) begin
          state_d = we_q ? IDLE : RDATA;
        end
      end
      RDATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write strobe only in the second ACCESS cycle, so one RAM edge per write.
  assign ram_we      = (state_q == ACCESS) && (gnt_q == 2'b00) && we_q;
  assign ram_address = (state_q == ACCESS) ? addr_q  : '0;
  assign ram_wdata   = (state_q == ACCESS) ? wdata_q : '0;
  assign rdata       = (state_q == RDATA)  ? ram_rdata : '0;
  assign p0_rvalid   = (state_q == RDATA) && !port_q;
  assign p1_rvalid   = (state_q == RDATA) &&  port_q;
  assign p0_gnt      = gnt_q[0];
  assign p1_gnt      = gnt_q[1];
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_arbiter
// Brief  : Directed bench for ram_arbiter, RR=1 and RR=0 instances side by side.
// Rev    : 1.0
// ============================================================================
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [9:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic       rr_gnt0, rr_gnt1, rr_rv0, rr_rv1, rr_busy, rr_ram_we;
  logic [9:0] rr_rdata, rr_ram_address, rr_ram_wdata, rr_ram_rdata;
  logic       fp_gnt0, fp_gnt1, fp_rv0, fp_rv1, fp_busy, fp_ram_we;
  logic [9:0] fp_rdata, fp_ram_address, fp_ram_wdata, fp_ram_rdata;

  logic [9:0] rr_mem [0:1023];
  logic [9:0] fp_mem [0:1023];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.RR(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(rr_gnt0), .p1_gnt(rr_gnt1), .p0_rvalid(rr_rv0), .p1_rvalid(rr_rv1),
    .rdata(rr_rdata), .busy(rr_busy), .ram_we(rr_ram_we),
    .ram_address(rr_ram_address), .ram_wdata(rr_ram_wdata), .ram_rdata(rr_ram_rdata)
  );

  ram_arbiter #(.RR(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(fp_gnt0), .p1_gnt(fp_gnt1), .p0_rvalid(fp_rv0), .p1_rvalid(fp_rv1),
    .rdata(fp_rdata), .busy(fp_busy), .ram_we(fp_ram_we),
    .ram_address(fp_ram_address), .ram_wdata(fp_ram_wdata), .ram_rdata(fp_ram_rdata)
  );

  always @(posedge clk) begin
    if (rr_ram_we) rr_mem[rr_ram_address] <= rr_ram_wdata;
    rr_ram_rdata <= rr_mem[rr_ram_address];
    if (fp_ram_we) fp_mem[fp_ram_address] <= fp_ram_wdata;
    fp_ram_rdata <= fp_mem[fp_ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [9:0] d);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = a; p0_wdata = d;
    tick();
    p0_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rr_mem[i] = 10'h000;
      fp_mem[i] = 10'h000;
    end
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    tick();
    tick();
    chk("rst_busy",  {31'd0, rr_busy}, 32'd0);
    chk("rst_gnt",   {30'd0, rr_gnt1, rr_gnt0}, 32'd0);
    chk("rst_addr",  {22'd0, rr_ram_address}, 32'd0);
    chk("rst_rdata", {22'd0, fp_rdata}, 32'd0);

    // Single write, request already pending while reset is held.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h005; p0_wdata = 10'h2AA;
    tick();
    chk("wr_no_gnt_in_rst", {30'd0, fp_gnt0, rr_gnt0}, 32'd0);
    rst = 1'b0;
    tick();
    chk("wr_gnt",       {30'd0, fp_gnt0, rr_gnt0}, 32'd3);
    chk("wr_busy1",     {31'd0, rr_busy}, 32'd1);
    chk("wr_we_gntcyc", {31'd0, rr_ram_we}, 32'd0);
    p0_req = 1'b0;
    tick();
    chk("wr_gnt_pulse", {31'd0, rr_gnt0}, 32'd0);
    chk("wr_ram_we",    {30'd0, fp_ram_we, rr_ram_we}, 32'd3);
    chk("wr_ram_addr",  {22'd0, rr_ram_address}, 32'h005);
    chk("wr_ram_wdata", {22'd0, rr_ram_wdata}, 32'h2AA);
    chk("wr_busy2",     {31'd0, rr_busy}, 32'd1);
    tick();
    chk("wr_idle",      {30'd0, rr_busy, rr_ram_we}, 32'd0);

    do_write(10'h001, 10'h011);
    do_write(10'h002, 10'h022);
    chk("mem_001", {22'd0, fp_mem[1]}, 32'h011);

    // Read-back through port 1.
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h005;
    tick();
    chk("rd_gnt1", {28'd0, fp_gnt1, fp_gnt0, rr_gnt1, rr_gnt0}, 32'b1010);
    p1_req = 1'b0;
    tick();
    chk("rd_rv_early", {30'd0, rr_rv1, rr_rv0}, 32'd0);
    tick();
    chk("rd_rv1",    {28'd0, fp_rv1, fp_rv0, rr_rv1, rr_rv0}, 32'b1010);
    chk("rd_rdata",  {22'd0, rr_rdata}, 32'h2AA);
    tick();
    chk("rd_rdata0", {22'd0, rr_rdata}, 32'd0);

    // Continuous conflict: p0 reads 0x001, p1 reads 0x002.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h001;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h002;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr_gnt_%0d", k), {30'd0, rr_gnt1, rr_gnt0},
          (k % 2 == 0) ? 32'b01 : 32'b10);
      chk($sformatf("fp_gnt_%0d", k), {30'd0, fp_gnt1, fp_gnt0}, 32'b01);
      tick();
      tick();
      chk($sformatf("rr_rv_%0d", k), {30'd0, rr_rv1, rr_rv0},
          (k % 2 == 0) ? 32'b01 : 32'b10);
      chk($sformatf("rr_rdata_%0d", k), {22'd0, rr_rdata},
          (k % 2 == 0) ? 32'h011 : 32'h022);
      chk($sformatf("fp_rv_%0d", k), {30'd0, fp_rv1, fp_rv0}, 32'b01);
      chk($sformatf("fp_rdata_%0d", k), {22'd0, fp_rdata}, 32'h011);
      if (k == 3) p0_req = 1'b0;
      tick();
      chk($sformatf("cf_idle_%0d", k), {30'd0, fp_busy, rr_busy}, 32'd0);
    end
    tick();
    chk("p1_alone_gnt", {28'd0, fp_gnt1, fp_gnt0, rr_gnt1, rr_gnt0}, 32'b1010);
    p1_req = 1'b0;
    tick();
    tick();
    chk("p1_alone_rdata", {12'd0, fp_rdata, rr_rdata}, {12'd0, 10'h022, 10'h022});
    tick();

    // Qualifiers change right after the grant.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h010; p0_wdata = 10'h155;
    tick();
    chk("cap_gnt", {31'd0, rr_gnt0}, 32'd1);
    p0_req = 1'b0; p0_addr = 10'h3FF; p0_wdata = 10'h0AA;
    tick();
    chk("cap_addr",  {21'd0, rr_ram_we, rr_ram_address}, {21'd0, 1'b1, 10'h010});
    chk("cap_wdata", {22'd0, rr_ram_wdata}, 32'h155);
    tick();
    chk("cap_mem010", {22'd0, rr_mem[16]}, 32'h155);
    chk("cap_mem3ff", {22'd0, rr_mem[1023]}, 32'h000);

    // Reset arriving in RDATA.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h001;
    tick();
    p0_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mr_rv",    {28'd0, fp_rv1, fp_rv0, rr_rv1, rr_rv0}, 32'd0);
    chk("mr_busy",  {30'd0, fp_busy, rr_busy}, 32'd0);
    chk("mr_rdata", {22'd0, rr_rdata}, 32'd0);
    tick();
    rst = 1'b0;
    chk("mr_rv_after", {30'd0, rr_rv0, fp_rv0}, 32'd0);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h001;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h002;
    tick();
    chk("mr_gnt", {28'd0, fp_gnt1, fp_gnt0, rr_gnt1, rr_gnt0}, 32'b0101);
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    tick();
    chk("mr_rv0",    {30'd0, rr_rv1, rr_rv0}, 32'b01);
    chk("mr_rdata1", {22'd0, rr_rdata}, 32'h011);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
